// File: rtl/spread_core.sv
// Avellaneda-Stoikov spread: gamma*sigma^2*(T-t) + L.
// Four-stage pipeline with saturating signed fixed-point arithmetic.
module spread_core #(
  parameter int FP_WORD_SIZE = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_curr_time,
  input  logic [FP_WORD_SIZE-1:0] i_volatility,
  input  logic                    i_data_valid,
  input  logic [FP_WORD_SIZE-1:0] i_logarithm,
  input  logic [FP_WORD_SIZE-1:0] i_risk_factor,
  input  logic [DATA_WIDTH-1:0]   i_terminal_time,
  output logic [FP_WORD_SIZE-1:0] o_spread,
  output logic                    o_data_valid
);

  localparam int W  = FP_WORD_SIZE;
  localparam int PW = 2 * W;
  localparam int XW = PW + DATA_WIDTH + 1;

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // Clamp a wide signed value into the W-bit signed range
  function automatic logic [W-1:0] sat(
    input logic signed [XW-1:0] v
  );
    if (v[XW-1:W-1] == {(XW-W+1){v[XW-1]}})
      return v[W-1:0];
    else
      return v[XW-1] ? MINV : MAXV;
  endfunction

  function automatic logic [W-1:0] fx_mul(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return sat(XW'(p >>> FRAC_BITS));
  endfunction

  logic                  v1, v2, v3;
  logic [DATA_WIDTH-1:0] rem1, rem2, rem3;
  logic [W-1:0]          sig1, gam1, gam2;
  logic [W-1:0]          log1, log2, log3;
  logic [W-1:0]          sq2, g3;
  logic [W-1:0]          p4, sum4;

  logic signed [XW-1:0] g_x, rem_x, p_x, l_x;

  always_comb begin
    g_x   = XW'($signed(g3));
    rem_x = $signed(XW'(rem3));
    p4    = sat(g_x * rem_x);
    p_x   = XW'($signed(p4));
    l_x   = XW'($signed(log3));
    sum4  = sat(p_x + l_x);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      rem1         <= '0;
      rem2         <= '0;
      rem3         <= '0;
      sig1         <= '0;
      gam1         <= '0;
      gam2         <= '0;
      log1         <= '0;
      log2         <= '0;
      log3         <= '0;
      sq2          <= '0;
      g3           <= '0;
      o_spread     <= '0;
      o_data_valid <= 1'b0;
    end else begin
      v1   <= i_data_valid;
      rem1 <= (i_terminal_time >= i_curr_time)
              ? i_terminal_time - i_curr_time : '0;
      sig1 <= i_volatility;
      gam1 <= i_risk_factor;
      log1 <= i_logarithm;

      v2   <= v1;
      sq2  <= fx_mul(sig1, sig1);
      gam2 <= gam1;
      rem2 <= rem1;
      log2 <= log1;

      v3   <= v2;
      g3   <= fx_mul(gam2, sq2);
      rem3 <= rem2;
      log3 <= log2;

      o_data_valid <= v3;
      if (v3)
        o_spread <= sum4;
    end
  end

endmodule

// File: tb/tb_spread_core.sv
// Bench for spread_core: scoreboarded results checked for value and
// arrival cycle, plus reset, hold and mid-flight reset scenarios.
module tb_spread_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] curr_time = '0;
  logic [63:0] volatility = '0;
  logic        data_valid = 1'b0;
  logic [63:0] logarithm = '0;
  logic [63:0] risk_factor = '0;
  logic [31:0] terminal_time = '0;
  logic [63:0] spread;
  logic        out_valid;

  spread_core dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_curr_time     (curr_time),
    .i_volatility    (volatility),
    .i_data_valid    (data_valid),
    .i_logarithm     (logarithm),
    .i_risk_factor   (risk_factor),
    .i_terminal_time (terminal_time),
    .o_spread        (spread),
    .o_data_valid    (out_valid)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] HALF    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] QUARTER = 64'h0000_0000_4000_0000;
  localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
  localparam logic [63:0] L_NOM   = 64'h0000_0001_8000_0000;
  localparam logic [63:0] MAXV    = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;

  typedef struct {
    logic [63:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Nominal case: gamma*sigma^2 = 1/16, so each tick of rem adds 2^28
  function automatic logic [63:0] nom_exp(input logic [31:0] rem);
    return ({32'd0, rem} << 28) + L_NOM;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h at cycle %0d",
                 spread, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (spread !== e.val || cyc !== e.due) begin
          errors++;
          $display("FAIL result got %h @%0d need %h @%0d",
                   spread, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic drive(input logic [63:0] sig, input logic [63:0] gam,
                       input logic [31:0] tt, input logic [31:0] t,
                       input logic [63:0] l, input logic [63:0] ev);
    exp_t e;
    @(posedge clk);
    #1;
    volatility    = sig;
    risk_factor   = gam;
    terminal_time = tt;
    curr_time     = t;
    logarithm     = l;
    data_valid    = 1'b1;
    e.val = ev;
    e.due = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    data_valid    = 1'b0;
    volatility    = {$urandom, $urandom};
    risk_factor   = {$urandom, $urandom};
    logarithm     = {$urandom, $urandom};
    terminal_time = $urandom;
    curr_time     = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d need 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (spread !== 64'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h/%b need 0/0",
               spread, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    drive(HALF, QUARTER, 100, 20, L_NOM, 64'h0000_0006_8000_0000);
    idle();
    wait_drain();
  endtask

  task automatic test_expired();
    drive(HALF, QUARTER, 100, 150, L_NOM, L_NOM);
    drive(HALF, QUARTER, 100, 100, L_NOM, L_NOM);
    idle();
    wait_drain();
  endtask

  task automatic test_saturation();
    drive(64'h0010_0000_0000_0000, ONE, 10, 0, ONE, MAXV);
    drive(HALF, NEG_ONE, 8, 0, ONE, 64'hFFFF_FFFF_0000_0000);
    drive(ONE, NEG_ONE, 3, 0, MINV, MINV);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++)
      drive(HALF, QUARTER, 100, 32'(i), L_NOM, nom_exp(32'(100 - i)));
    idle();
    wait_drain();
  endtask

  task automatic test_hold();
    logic [63:0] last;
    last = nom_exp(96);
    for (int i = 0; i < 8; i++) begin
      idle();
      @(negedge clk);
      checks++;
      if (spread !== last || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold got %h/%b need %h/0",
                 spread, out_valid, last);
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(HALF, QUARTER, 100, 20, L_NOM, 64'h0000_0006_8000_0000);
    idle();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (spread !== 64'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h/%b need 0/0",
               spread, out_valid);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || spread !== 64'd0) begin
        errors++;
        $display("FAIL flushed got %h/%b need 0/0",
                 spread, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_expired();
    test_saturation();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
